// File: rtl/fdn_mode_reg.sv
// fdn_mode_reg: WIDTH-bit hold/load/shift/mod-(MAXCNT+1) count register; FDN_DOWN_EN adds DIR down-count.
// Latency: 1 cycle, all outputs registered; no backpressure, EN=0 simply holds state.
module fdn_mode_reg #(
  parameter int          WIDTH  = 8,
  parameter int unsigned MAXCNT = 255,
  parameter int          size   = 50
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
`ifdef FDN_DOWN_EN
  input  logic             DIR,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             TC,
  output logic [size:0]    number
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAXCNT);
  localparam logic [WIDTH-1:0] LP_ZERO = '0;
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

`ifdef FDN_DOWN_EN
  localparam int LP_COST = 27*WIDTH + 20*WIDTH + 16 + 8*WIDTH;
`else
  localparam int LP_COST = 27*WIDTH + 20*WIDTH + 16;
`endif

  generate
    if (WIDTH < 2 || WIDTH > 32 || (64'(MAXCNT) >> WIDTH) != 64'd0) begin : g_param_bad
      $error("fdn_mode_reg: need 2<=WIDTH<=32 and MAXCNT < 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_so;
  logic             r_tc;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_so_nxt;
  logic             w_tc_nxt;

  always_comb begin
    w_q_nxt  = r_q;
    w_so_nxt = r_so;
    w_tc_nxt = 1'b0;
    if (EN) begin
      case (MODE)
        MODE_HOLD: ;
        MODE_LOAD: w_q_nxt = D;
        MODE_SHIFT: begin
          w_q_nxt  = {r_q[WIDTH-2:0], SI};
          w_so_nxt = r_q[WIDTH-1];
        end
        MODE_COUNT: begin
`ifdef FDN_DOWN_EN
          // Down-count: out-of-range values land on MAXCNT without flagging a wrap
          if (DIR) begin
            if (r_q == LP_ZERO) begin
              w_q_nxt  = LP_MAX;
              w_tc_nxt = 1'b1;
            end else if (r_q > LP_MAX) begin
              w_q_nxt = LP_MAX;
            end else begin
              w_q_nxt = r_q - LP_ONE;
            end
          end else
`endif
          if (r_q >= LP_MAX) begin
            w_q_nxt  = LP_ZERO;
            w_tc_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q + LP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_q  <= '0;
      r_so <= 1'b0;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_so <= w_so_nxt;
      r_tc <= w_tc_nxt;
    end
  end

  assign Q      = r_q;
  assign SO     = r_so;
  assign TC     = r_tc;
  assign number = (size+1)'(LP_COST);

endmodule

// File: tb/tb_fdn_mode_reg.sv
// Bench for fdn_mode_reg (WIDTH=8, MAXCNT=9): reference model feeds an expected-value queue,
// a monitor pops one entry per clock; directed checks cover reset, wrap, gating and shift.
module tb_fdn_mode_reg;

  localparam int         WIDTH = 8;
  localparam logic [7:0] MAXC  = 8'd9;
`ifdef FDN_DOWN_EN
  localparam int EXP_NUM = 456;
`else
  localparam int EXP_NUM = 392;
`endif

  typedef struct packed {
    logic [7:0] q;
    logic       so;
    logic       tc;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SI;
  logic             DIR;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic             TC;
  logic [50:0]      number;

  int n_cmp = 0;
  int n_err = 0;

  exp_t       sb[$];
  logic [7:0] m_q;
  logic       m_so;
  logic       m_tc;

  fdn_mode_reg #(.WIDTH(WIDTH), .MAXCNT(9)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .EN     (EN),
    .MODE   (MODE),
    .D      (D),
    .SI     (SI),
`ifdef FDN_DOWN_EN
    .DIR    (DIR),
`endif
    .Q      (Q),
    .SO     (SO),
    .TC     (TC),
    .number (number)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one clocked operation on the falling edge and queue the model's result.
  task automatic step(input logic en, input logic [1:0] mode, input logic [7:0] d,
                      input logic si, input logic dir);
    exp_t e;
    @(negedge CLK);
    EN = en; MODE = mode; D = d; SI = si; DIR = dir;
    m_tc = 1'b0;
    if (en) begin
      case (mode)
        2'b01: m_q = d;
        2'b10: begin
          m_so = m_q[7];
          m_q  = {m_q[6:0], si};
        end
        2'b11: begin
`ifdef FDN_DOWN_EN
          if (dir) begin
            if (m_q == 8'd0) begin
              m_q = MAXC; m_tc = 1'b1;
            end else if (m_q > MAXC) begin
              m_q = MAXC;
            end else begin
              m_q = m_q - 8'd1;
            end
          end else
`endif
          if (m_q >= MAXC) begin
            m_q = 8'd0; m_tc = 1'b1;
          end else begin
            m_q = m_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
    e.q = m_q; e.so = m_so; e.tc = m_tc;
    sb.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_q", Q, e.q);
        chk("sb_so", SO, e.so);
        chk("sb_tc", TC, e.tc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; EN = 1'b0; MODE = 2'b00; D = '0; SI = 1'b0; DIR = 1'b0;
    m_q = 8'd0; m_so = 1'b0; m_tc = 1'b0;
    #3;
    chk("rst_q", Q, 8'h00);
    chk("rst_so", SO, 1'b0);
    chk("rst_tc", TC, 1'b0);
    chk("number", number, EXP_NUM);
    @(negedge CLK);
    RESET = 1'b0;

    // Async reset mid-count with SO previously set
    step(1'b1, 2'b01, 8'h81, 1'b0, 1'b0);
    step(1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
    step(1'b1, 2'b01, 8'h37, 1'b0, 1'b0);
    chk("t1_pre_q", Q, 8'h37);
    chk("t1_pre_so", SO, 1'b1);
    @(negedge CLK);
    EN = 1'b1; MODE = 2'b11;
    #2 RESET = 1'b1;
    #1;
    chk("t1_async_q", Q, 8'h00);
    chk("t1_async_so", SO, 1'b0);
    chk("t1_async_tc", TC, 1'b0);
    m_q = 8'd0; m_so = 1'b0; m_tc = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #2;
      chk("t1_hold_q", Q, 8'h00);
    end
    @(negedge CLK);
    RESET = 1'b0; EN = 1'b0;

    // Load 7 then count through the wrap
    step(1'b1, 2'b01, 8'd7, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'd0, 1'b0, 1'b0); chk("t2_q8", Q, 8'd8); chk("t2_tc8", TC, 1'b0);
    step(1'b1, 2'b11, 8'd0, 1'b0, 1'b0); chk("t2_q9", Q, 8'd9); chk("t2_tc9", TC, 1'b0);
    step(1'b1, 2'b11, 8'd0, 1'b0, 1'b0); chk("t2_q0", Q, 8'd0); chk("t2_tc0", TC, 1'b1);
    step(1'b1, 2'b11, 8'd0, 1'b0, 1'b0); chk("t2_q1", Q, 8'd1); chk("t2_tc1", TC, 1'b0);

    // Shift
    step(1'b1, 2'b01, 8'h81, 1'b0, 1'b0);
    step(1'b1, 2'b10, 8'h00, 1'b1, 1'b0); chk("t3_q03", Q, 8'h03); chk("t3_so1", SO, 1'b1);
    step(1'b1, 2'b10, 8'h00, 1'b0, 1'b0); chk("t3_q06", Q, 8'h06); chk("t3_so0", SO, 1'b0);

    // EN gating at terminal count
    step(1'b1, 2'b01, 8'd9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b11, 8'h00, 1'b0, 1'b0);
      chk("t4_en0_q", Q, 8'd9);
      chk("t4_en0_tc", TC, 1'b0);
    end
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0); chk("t4_q", Q, 8'd0); chk("t4_tc", TC, 1'b1);
    step(1'b1, 2'b00, 8'h55, 1'b1, 1'b0); chk("t4_hold_tc", TC, 1'b0);

    // Out-of-range value counted
    step(1'b1, 2'b01, 8'hF0, 1'b0, 1'b0); chk("t5_load", Q, 8'hF0);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0); chk("t5_up_q", Q, 8'd0); chk("t5_up_tc", TC, 1'b1);
`ifdef FDN_DOWN_EN
    step(1'b1, 2'b01, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b1); chk("t5_dn_q", Q, 8'd9); chk("t5_dn_tc", TC, 1'b0);
    step(1'b1, 2'b01, 8'd0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b1); chk("t6_q", Q, 8'd9); chk("t6_tc", TC, 1'b1);
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b1); chk("t6_q8", Q, 8'd8); chk("t6_tc8", TC, 1'b0);
`endif

    // Random mix against the reference model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge CLK);
    EN = 1'b0;
    @(posedge CLK);
    #3;
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
